// File: rtl/sram_like_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_responder_pkg
//
// Shared types and constants for the SRAM-like memory responder.
//   - entry_t   : one queued request {wr, wstrb, index, wdata}
//   - AGE_W     : width of the per-slot age counters (LATENCY up to 15)
//   - size_e    : request size encodings (informational on this interface)
//   - strb_mask : expands a 4-bit byte strobe into a 32-bit bit mask
//
// The word index field is sized for the largest storage depth the responder
// can be built with; an instance uses only its low AW_WORDS bits.
// -----------------------------------------------------------------------------
package sram_like_responder_pkg;

    // Age counters only need to reach LATENCY, whose legal maximum is 15.
    localparam int unsigned AGE_W = 4;

    // Widest word index a 32-bit byte address can carry (addr[31:2]).
    localparam int unsigned IDX_W_MAX = 30;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic                 wr;
        logic [3:0]           wstrb;
        logic [IDX_W_MAX-1:0] index;
        logic [31:0]          wdata;
    } entry_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/sram_like_responder_resp_queue.sv
// -----------------------------------------------------------------------------
// sram_like_responder_resp_queue
//
// QDEPTH-entry circular buffer of accepted requests. Each slot carries an age
// counter that starts at 0 on push and counts up once per cycle, saturating at
// LATENCY. The head is ready to answer once its age has reached LATENCY, so a
// request pushed at edge t is ready in cycle t+LATENCY at the earliest; a
// request that sat behind a slow head is ready as soon as it becomes head.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high; clears pointers, count, ages
//   push       in   write push_entry into the tail slot (caller ensures !full)
//   push_entry in   request payload to store
//   pop        in   retire the head slot at the end of this cycle
//   full       out  registered count has reached QDEPTH
//   head_ready out  head slot occupied and its age equals LATENCY
//   head_entry out  payload of the head slot
// -----------------------------------------------------------------------------
module sram_like_responder_resp_queue
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned QDEPTH  = 2,
    parameter int unsigned LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output logic   full,
    output logic   head_ready,
    output entry_t head_entry
);

    localparam int unsigned      PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [AGE_W-1:0] age_q [QDEPTH];
    logic [AGE_W-1:0] age_d [QDEPTH];
    entry_t           slot_q [QDEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every variable this block writes is given a value before any
    // conditional logic, so no path leaves one unassigned and no latch is
    // inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;

        for (int i = 0; i < QDEPTH; i++) begin
            age_d[i] = age_q[i];
            if (vld_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = next_ptr(head_q);
        end

        // Push is applied after pop: a freshly accepted slot always starts at
        // age 0 even if the caller pops and pushes in the same cycle.
        if (push) begin
            vld_d[tail_q] = 1'b1;
            age_d[tail_q] = '0;
            tail_d        = next_ptr(tail_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
            for (int i = 0; i < QDEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // NOTE: slot payloads are deliberately left out of reset; a slot is only
    // read once its valid bit is set, so clearing the data would buy nothing
    // and would keep the array from mapping onto plain storage.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[tail_q] <= push_entry;
        end
    end

    always_comb begin
        full       = (count_q == CNT_FULL);
        head_ready = vld_q[head_q] && (age_q[head_q] == AGE_MAX);
        head_entry = slot_q[head_q];
    end

endmodule

// File: rtl/sram_like_responder.sv
// -----------------------------------------------------------------------------
// sram_like_responder
//
// Memory side of the CPU's SRAM-like request/response interface. Requests are
// accepted on req && addr_ok, queued in order, and answered one per cycle on
// data_ok once LATENCY cycles have passed since their accept edge. Reads
// sample the word array combinationally in the data_ok cycle; writes merge
// the strobed byte lanes into the array at the end of the data_ok cycle. As
// requests retire strictly in order, a read always sees every earlier write.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high; drops all pending requests
//   req      in   request valid
//   wr       in   1 = write, 0 = read
//   size     in   byte/half/word; informational, wstrb selects the lanes
//   wstrb    in   byte write enables (writes only)
//   addr     in   byte address; word index is addr[AW_WORDS+1:2]
//   wdata    in   write data
//   stall    in   backpressure; forces addr_ok low
//   addr_ok  out  request accepted this cycle when req is also high
//   data_ok  out  one-cycle response pulse, in request order
//   rdata    out  read data with data_ok, zero otherwise
// -----------------------------------------------------------------------------
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int unsigned AW_WORDS = 10,
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW_WORDS;

    logic                push;
    logic                pop;
    logic                full;
    logic                head_ready;
    entry_t              push_entry;
    entry_t              head_entry;
    logic [AW_WORDS-1:0] head_idx;

    logic                mem_we;
    logic [31:0]         mem_wmask;
    logic [31:0]         mem_rword;
    logic [31:0]         mem_wword;
    logic [31:0]         mem_q [DEPTH];

    // size only documents the access, high address bits alias and addr[1:0]
    // is replaced by wstrb; gathering them here marks them as intentionally
    // unused.
    logic unused_bits;
    assign unused_bits = ^{size, addr, head_entry.index};

    sram_like_responder_resp_queue #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_resp_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .head_ready (head_ready),
        .head_entry (head_entry)
    );

    // Accept and respond. full comes from the registered count, so a head
    // retiring this cycle frees its slot for the next cycle, not this one.
    always_comb begin
        addr_ok = !reset && !stall && !full;
        push    = req && addr_ok;

        push_entry.wr    = wr;
        push_entry.wstrb = wstrb;
        push_entry.index = IDX_W_MAX'(addr[AW_WORDS+1:2]);
        push_entry.wdata = wdata;

        data_ok  = !reset && head_ready;
        pop      = data_ok;
        head_idx = head_entry.index[AW_WORDS-1:0];
    end

    // Storage access: one combinational read of the head's word serves both
    // the read response and the read-modify-write merge of a store.
    always_comb begin
        mem_rword = mem_q[head_idx];
        mem_we    = data_ok && head_entry.wr;
        mem_wmask = strb_mask(head_entry.wstrb);
        mem_wword = (mem_rword & ~mem_wmask) | (head_entry.wdata & mem_wmask);
        rdata     = (data_ok && !head_entry.wr) ? mem_rword : 32'h0;
    end

    // Word array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[head_idx] <= mem_wword;
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_like_responder
//
// Directed scenarios with hand-derived expectations, followed by a randomized
// run checked cycle by cycle against a transaction-level model: a queue of
// pending requests stamped with the cycle they become due, and a plain word
// array standing in for the storage.
// -----------------------------------------------------------------------------
module tb_sram_like_responder;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int QD    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic [1:0]  size  = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall = 1'b0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    // Free-running cycle number, advanced on each rising edge; sampled at the
    // falling edge it names the current cycle.
    int ncyc = 0;

    // Response monitor: cycle and data of every data_ok pulse, plus a count of
    // cycles where rdata was non-zero without data_ok.
    int          dok_cyc[$];
    logic [31:0] dok_rd[$];
    int          rd_leak = 0;

    sram_like_responder #(
        .AW_WORDS (AW),
        .LATENCY  (LAT),
        .QDEPTH   (QD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .stall   (stall),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        ncyc++;
    end

    initial forever begin
        @(negedge clk);
        if (data_ok === 1'b1) begin
            dok_cyc.push_back(ncyc);
            dok_rd.push_back(rdata);
        end else if (rdata !== 32'h0) begin
            rd_leak++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    function automatic int cyc_at(input int i);
        return (i < dok_cyc.size()) ? dok_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (i < dok_rd.size()) ? dok_rd[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic clear_mon();
        dok_cyc.delete();
        dok_rd.delete();
        rd_leak = 0;
    endtask

    task automatic drain(input int n);
        req   = 1'b0;
        stall = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds a request until it is accepted; returns the accept cycle. Ends one
    // step after the accepting edge with req low.
    task automatic issue(input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int acc);
        req   = 1'b1;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
        acc   = -1;
        for (int k = 0; k < 30 && acc < 0; k++) begin
            @(negedge clk);
            if (addr_ok === 1'b1) acc = ncyc;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL issue_timeout addr=%h: addr_ok stayed low for 30 cycles", a);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b1;
        wr    = 1'b0;
        addr  = 32'h10;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (addr_ok !== 1'b0) begin bad++; $display("FAIL reset_addr_ok got=%b exp=0", addr_ok); end
            total++;
            if (data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok got=%b exp=0", data_ok); end
            total++;
            if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL post_reset_addr_ok got=%b exp=1", addr_ok); end
        total++;
        if (data_ok !== 1'b0) begin bad++; $display("FAIL post_reset_data_ok got=%b exp=0", data_ok); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        int c;
        issue(1'b1, 4'hF, 32'h10, 32'h1122_3344, c);
        drain(6);
        clear_mon();
        issue(1'b0, 4'h0, 32'h10, 32'h0, c);
        drain(6);
        total++;
        if (dok_cyc.size() != 1) begin bad++; $display("FAIL single_read_pulses got=%0d exp=1", dok_cyc.size()); end
        total++;
        if (cyc_at(0) != c + 1 + LAT) begin bad++; $display("FAIL single_read_latency got=%0d exp=%0d", cyc_at(0), c + 1 + LAT); end
        total++;
        if (rd_at(0) !== 32'h1122_3344) begin bad++; $display("FAIL single_read_data got=%h exp=11223344", rd_at(0)); end
        total++;
        if (rd_leak != 0) begin bad++; $display("FAIL single_read_idle_rdata got=%0d exp=0", rd_leak); end
    endtask

    task automatic test_write_then_read();
        int c0, c1;
        clear_mon();
        issue(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD, c0);
        issue(1'b0, 4'h0, 32'h20, 32'h0, c1);
        drain(6);
        total++;
        if (c1 != c0 + 1) begin bad++; $display("FAIL wr_rd_back_to_back got=%0d exp=%0d", c1, c0 + 1); end
        total++;
        if (dok_cyc.size() != 2) begin bad++; $display("FAIL wr_rd_pulses got=%0d exp=2", dok_cyc.size()); end
        total++;
        if (cyc_at(0) != c0 + 1 + LAT) begin bad++; $display("FAIL wr_rd_first got=%0d exp=%0d", cyc_at(0), c0 + 1 + LAT); end
        total++;
        if (cyc_at(1) != c0 + 2 + LAT) begin bad++; $display("FAIL wr_rd_second got=%0d exp=%0d", cyc_at(1), c0 + 2 + LAT); end
        total++;
        if (rd_at(0) !== 32'h0) begin bad++; $display("FAIL wr_rd_write_rdata got=%h exp=0", rd_at(0)); end
        total++;
        if (rd_at(1) !== 32'hAABB_CCDD) begin bad++; $display("FAIL wr_rd_data got=%h exp=aabbccdd", rd_at(1)); end
    endtask

    task automatic test_byte_strobe();
        int c;
        clear_mon();
        issue(1'b1, 4'hF, 32'h20, 32'h0, c);
        issue(1'b1, 4'b0100, 32'h20, 32'h1234_5678, c);
        // Same word through aliased high bits and non-zero low bits.
        issue(1'b0, 4'h0, 32'hABC0_0023, 32'h0, c);
        drain(8);
        total++;
        if (dok_cyc.size() != 3) begin bad++; $display("FAIL strobe_pulses got=%0d exp=3", dok_cyc.size()); end
        total++;
        if (rd_at(2) !== 32'h0034_0000) begin bad++; $display("FAIL strobe_data got=%h exp=00340000", rd_at(2)); end
    endtask

    task automatic test_full_queue();
        int acc_c[3];
        int n_acc = 0;
        logic aok_hist[$];
        clear_mon();
        req  = 1'b1;
        wr   = 1'b0;
        addr = 32'h10;
        for (int k = 0; k < 20 && n_acc < 3; k++) begin
            @(negedge clk);
            aok_hist.push_back(addr_ok);
            if (addr_ok === 1'b1) begin
                acc_c[n_acc] = ncyc;
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        drain(8);
        total++;
        if (n_acc != 3) begin bad++; $display("FAIL full_accepts got=%0d exp=3", n_acc); end
        else begin
            total++;
            if (aok_hist[0] !== 1'b1 || aok_hist[1] !== 1'b1 || aok_hist[2] !== 1'b0) begin
                bad++;
                $display("FAIL full_addr_ok_pattern got=%b%b%b exp=110", aok_hist[0], aok_hist[1], aok_hist[2]);
            end
            total++;
            if (acc_c[2] != acc_c[0] + 2 + LAT) begin bad++; $display("FAIL full_reopen got=%0d exp=%0d", acc_c[2], acc_c[0] + 2 + LAT); end
            total++;
            if (acc_c[2] != cyc_at(0) + 1) begin bad++; $display("FAIL full_reopen_after_dok got=%0d exp=%0d", acc_c[2], cyc_at(0) + 1); end
            total++;
            if (cyc_at(1) != acc_c[1] + 1 + LAT || cyc_at(2) != acc_c[2] + 1 + LAT) begin
                bad++;
                $display("FAIL full_resp_cycles got=%0d,%0d exp=%0d,%0d", cyc_at(1), cyc_at(2), acc_c[1] + 1 + LAT, acc_c[2] + 1 + LAT);
            end
        end
        total++;
        if (dok_cyc.size() != 3) begin bad++; $display("FAIL full_pulses got=%0d exp=3", dok_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_at(i) !== 32'h1122_3344) begin bad++; $display("FAIL full_data%0d got=%h exp=11223344", i, rd_at(i)); end
        end
    endtask

    task automatic test_backpressure();
        int c;
        clear_mon();
        stall = 1'b1;
        req   = 1'b1;
        wr    = 1'b0;
        addr  = 32'h10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (addr_ok !== 1'b0) begin bad++; $display("FAIL stall_addr_ok cyc%0d got=%b exp=0", k, addr_ok); end
            @(posedge clk);
            #1;
        end
        total++;
        if (dok_cyc.size() != 0) begin bad++; $display("FAIL stall_data_ok got=%0d exp=0", dok_cyc.size()); end
        stall = 1'b0;
        @(negedge clk);
        c = ncyc;
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL unstall_addr_ok got=%b exp=1", addr_ok); end
        @(posedge clk);
        #1;
        drain(6);
        total++;
        if (dok_cyc.size() != 1 || cyc_at(0) != c + 1 + LAT) begin
            bad++;
            $display("FAIL unstall_resp pulses=%0d cyc=%0d exp_cyc=%0d", dok_cyc.size(), cyc_at(0), c + 1 + LAT);
        end
    endtask

    task automatic test_reset_mid_op();
        int c;
        issue(1'b1, 4'hF, 32'h40, 32'h0101_0101, c);
        issue(1'b1, 4'hF, 32'h44, 32'h0202_0202, c);
        drain(6);
        clear_mon();
        issue(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF, c);
        issue(1'b1, 4'hF, 32'h44, 32'hCAFE_BABE, c);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (data_ok !== 1'b0 || addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL midreset_outputs got=%b%b exp=00", data_ok, addr_ok);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (addr_ok !== 1'b1) begin bad++; $display("FAIL midreset_reopen got=%b exp=1", addr_ok); end
        @(posedge clk);
        #1;
        drain(6);
        total++;
        if (dok_cyc.size() != 0) begin bad++; $display("FAIL midreset_stale_data_ok got=%0d exp=0", dok_cyc.size()); end
        clear_mon();
        issue(1'b0, 4'h0, 32'h40, 32'h0, c);
        issue(1'b0, 4'h0, 32'h44, 32'h0, c);
        drain(6);
        total++;
        if (rd_at(0) !== 32'h0101_0101) begin bad++; $display("FAIL midreset_word0 got=%h exp=01010101", rd_at(0)); end
        total++;
        if (rd_at(1) !== 32'h0202_0202) begin bad++; $display("FAIL midreset_word1 got=%h exp=02020202", rd_at(1)); end
    endtask

    // ------------------------------------------------------- reference model
    typedef struct {
        logic        wr;
        logic [3:0]  strb;
        int          idx;
        logic [31:0] wdata;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] mmem [DEPTH];
    int          mcyc = 0;

    // Expected outputs for the current cycle's inputs, then advances the
    // model across the coming clock edge.
    task automatic model_step(output logic e_aok, output logic e_dok, output logic [31:0] e_rd);
        e_aok = !reset && !stall && (pend.size() < QD);
        e_dok = 1'b0;
        e_rd  = 32'h0;
        if (!reset && pend.size() > 0 && mcyc >= pend[0].due) begin
            e_dok = 1'b1;
            if (pend[0].wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (pend[0].strb[b]) mmem[pend[0].idx][8*b +: 8] = pend[0].wdata[8*b +: 8];
                end
            end else begin
                e_rd = mmem[pend[0].idx];
            end
            void'(pend.pop_front());
        end
        if (reset) begin
            pend.delete();
        end else if (req && e_aok) begin
            pend.push_back('{wr: wr, strb: wstrb, idx: int'((addr >> 2) % DEPTH),
                             wdata: wdata, due: mcyc + 1 + LAT});
        end
        mcyc++;
    endtask

    task automatic test_random();
        logic        e_aok, e_dok;
        logic [31:0] e_rd;
        int widx  = 0;
        int quiet = 0;
        pend.delete();
        for (int n = 0; n < 420; n++) begin
            if (n < 2) begin
                reset = 1'b1; req = 1'b0; stall = 1'b0;
            end else if (widx < 8) begin
                reset = 1'b0; stall = 1'b0; req = 1'b1; wr = 1'b1; wstrb = 4'hF;
                addr  = 32'(widx) << 2;
                wdata = $urandom();
            end else if (quiet < 8) begin
                reset = 1'b0; req = 1'b0; stall = 1'b0;
                quiet++;
            end else begin
                reset = ($urandom_range(99) == 0);
                stall = ($urandom_range(4) == 0);
                req   = ($urandom_range(9) < 7);
                wr    = 1'($urandom_range(1));
                wstrb = 4'($urandom_range(15));
                addr  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(7)) << 2) | 32'($urandom_range(3));
                wdata = $urandom();
            end
            @(negedge clk);
            model_step(e_aok, e_dok, e_rd);
            total++;
            if (addr_ok !== e_aok) begin bad++; $display("FAIL rand_addr_ok n=%0d got=%b exp=%b", n, addr_ok, e_aok); end
            total++;
            if (data_ok !== e_dok) begin bad++; $display("FAIL rand_data_ok n=%0d got=%b exp=%b", n, data_ok, e_dok); end
            total++;
            if (rdata !== e_rd) begin bad++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, rdata, e_rd); end
            if (n >= 2 && widx < 8 && e_aok) widx++;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        drain(2);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_byte_strobe();
        test_full_queue();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
